wb_stage_writeback: RTL and testbench
=====================================

Name: wb_stage_writeback

Overview:
- MEM/WB pipeline register plus write-back formatting for the RV32I core.
- Captures the retiring instruction's results from the memory stage and selects the write-back source (ALU, load data, or PC+4).
- Byte/halfword-extracts and sign/zero-extends load data.
- Drives the register-file write port: data word, write enable, and one-hot row select. Also provides a forwarding tap and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 supported, load extraction is defined for 32-bit words.
- REG_COUNT, 32, number of architectural registers; width of the one-hot select.
- RD_W, 5, destination register index width (log2 REG_COUNT).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold stage contents.
- flush  input  1  insert bubble; has priority over stall.
- valid_in  input  1  MEM-stage instruction valid.
- reg_write_in  input  1  instruction writes rd.
- rd_in  input  RD_W  destination register index.
- wb_sel_in  input  2  00 ALU, 01 load, 10 PC+4, 11 ALU.
- funct3_in  input  3  load type.
- byte_off_in  input  2  address[1:0] of load.
- alu_result_in  input  XLEN  ALU result.
- pc_plus4_in  input  XLEN  link value.
- mem_rdata_in  input  XLEN  raw aligned word from data memory.
- Rin  output  XLEN  register-file write data.
- we  output  1  register-file write enable.
- S  output  REG_COUNT  one-hot row select.
- fwd_valid  output  1  equals we; forwarding tap valid.
- fwd_rd  output  RD_W  registered rd.
- fwd_data  output  XLEN  equals Rin.
- retire_count  output  32  instructions retired since reset.

Behaviour:
- Stage register holds: valid_r, reg_write_r, rd_r, wb_sel_r, funct3_r, off_r, alu_r, pc4_r, mem_r.
- Reset (reset=0, async): all stage fields 0, retire_count 0. This gives we=0, S=0, Rin=0, fwd_valid=0, fwd_rd=0.
- Rising edge update, evaluated in priority order:
  - flush=1: valid_r<=0, reg_write_r<=0, other fields don't-care (cleared to 0).
  - else stall=1: hold all fields.
  - else: capture all *_in fields.
- retire_count increments by 1 on any edge where valid_r=1 and (flush=1 or stall=0). It wraps 0xFFFFFFFF -> 0. It never increments while held by stall.
- Outputs are combinational from the stage register only (no input-to-output paths). Latency:
  - Inputs at edge N appear on Rin/we/S after edge N.
  - The register-file write lands at edge N+1.
- we = valid_r & reg_write_r & (rd_r != 0). x0 is never written.
- S = one-hot(rd_r) when we=1, else all zeros. Exactly one bit is set when we=1.
- Write-back select:
  - 00 or 11: Rin=alu_r.
  - 10: Rin=pc4_r.
  - 01: Rin=load_ext.
- load_ext, little-endian:
  - Byte = mem_r[8*off_r+7 : 8*off_r].
  - Half = mem_r[31:16] if off_r[1], else mem_r[15:0]; off_r[0] is ignored.
  - funct3 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
  - funct3 001 LH: sign-extend half. 101 LHU: zero-extend half.
  - funct3 010 LW, and 011/110/111: full word, offset ignored.
- Rin is driven even when we=0; the consumer gates on we.
- While stalled, we stays asserted for the held instruction. Repeated identical writes are permitted and harmless.
- Simultaneous flush and stall: flush wins. The held instruction is counted and leaves; a bubble enters.
- Reset mid-stall or mid-flush: async clear takes effect immediately, with no write on the following edge.

Test Plan:
- Reset, then ALU write: valid_in=1, reg_write_in=1, rd_in=5, wb_sel=00, alu=0x12345678. After 1 edge: we=1, S=0x00000020, Rin=0x12345678. retire_count=1 after next edge.
- x0 suppression: rd_in=0, reg_write_in=1, valid_in=1. Response: we=0, S=0, fwd_valid=0. retire_count still increments.
- Loads with mem_rdata=0x80FF7F01, wb_sel=01, rd=3:
  - LB off 3 -> 0xFFFFFF80. LBU off 3 -> 0x00000080. LB off 1 -> 0x0000007F.
  - LH off 2 -> 0xFFFF80FF. LHU off 0 -> 0x00007F01. LW off 2 -> 0x80FF7F01.
- Stall/flush: capture rd=7 and hold stall=1 for 3 edges. Outputs are unchanged and retire_count is unchanged. Then assert stall=1 and flush=1 together. After the edge: we=0, retire_count +1.
- JAL link: wb_sel=10, pc_plus4=0x00000104, rd=1. Response: Rin=0x00000104, S=0x00000002. Then pull reset low between edges: we drops to 0 immediately and retire_count=0.
- Counter wrap: with retire_count forced/preloaded to 0xFFFFFFFF via a backdoor, retire one instruction -> retire_count=0x00000000.

Source files
------------

// File: rtl/wb_stage_writeback.sv
// MEM/WB pipeline register with write-back source selection and load formatting.
// Drives the register-file write port, a forwarding tap and a retired-instruction counter.
module wb_stage_writeback #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int RD_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic                 reg_write_in,
    input  logic [RD_W-1:0]      rd_in,
    input  logic [1:0]           wb_sel_in,
    input  logic [2:0]           funct3_in,
    input  logic [1:0]           byte_off_in,
    input  logic [XLEN-1:0]      alu_result_in,
    input  logic [XLEN-1:0]      pc_plus4_in,
    input  logic [XLEN-1:0]      mem_rdata_in,
    output logic [XLEN-1:0]      Rin,
    output logic                 we,
    output logic [REG_COUNT-1:0] S,
    output logic                 fwd_valid,
    output logic [RD_W-1:0]      fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic [31:0]          retire_count
);

    logic            valid_reg;
    logic            reg_write_reg;
    logic [RD_W-1:0] rd_reg;
    logic [1:0]      wb_sel_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      off_reg;
    logic [XLEN-1:0] alu_reg;
    logic [XLEN-1:0] pc4_reg;
    logic [XLEN-1:0] mem_reg;
    logic [31:0]     retire_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg        <= 1'b0;
            reg_write_reg    <= 1'b0;
            rd_reg           <= '0;
            wb_sel_reg       <= '0;
            funct3_reg       <= '0;
            off_reg          <= '0;
            alu_reg          <= '0;
            pc4_reg          <= '0;
            mem_reg          <= '0;
            retire_count_reg <= '0;
        end else begin
            // The occupant retires whenever it leaves the stage, including via flush.
            if (valid_reg && (flush || !stall))
                retire_count_reg <= retire_count_reg + 32'd1;
            if (flush) begin
                valid_reg     <= 1'b0;
                reg_write_reg <= 1'b0;
                rd_reg        <= '0;
                wb_sel_reg    <= '0;
                funct3_reg    <= '0;
                off_reg       <= '0;
                alu_reg       <= '0;
                pc4_reg       <= '0;
                mem_reg       <= '0;
            end else if (!stall) begin
                valid_reg     <= valid_in;
                reg_write_reg <= reg_write_in;
                rd_reg        <= rd_in;
                wb_sel_reg    <= wb_sel_in;
                funct3_reg    <= funct3_in;
                off_reg       <= byte_off_in;
                alu_reg       <= alu_result_in;
                pc4_reg       <= pc_plus4_in;
                mem_reg       <= mem_rdata_in;
            end
        end
    end

    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_ext;

    always_comb begin
        load_byte = mem_reg[7:0];
        case (off_reg)
            2'd0: load_byte = mem_reg[7:0];
            2'd1: load_byte = mem_reg[15:8];
            2'd2: load_byte = mem_reg[23:16];
            2'd3: load_byte = mem_reg[31:24];
            default: load_byte = mem_reg[7:0];
        endcase
        load_half = off_reg[1] ? mem_reg[31:16] : mem_reg[15:0];
    end

    always_comb begin
        load_ext = mem_reg;
        case (funct3_reg)
            3'b000: load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100: load_ext = {{(XLEN-8){1'b0}}, load_byte};
            3'b001: load_ext = {{(XLEN-16){load_half[15]}}, load_half};
            3'b101: load_ext = {{(XLEN-16){1'b0}}, load_half};
            default: load_ext = mem_reg;
        endcase
    end

    always_comb begin
        Rin = alu_reg;
        case (wb_sel_reg)
            2'b01: Rin = load_ext;
            2'b10: Rin = pc4_reg;
            default: Rin = alu_reg;
        endcase
    end

    assign we           = valid_reg & reg_write_reg & (rd_reg != '0);
    assign fwd_valid    = we;
    assign fwd_rd       = rd_reg;
    assign fwd_data     = Rin;
    assign retire_count = retire_count_reg;

    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_row_sel
            assign S[gi] = we && (rd_reg == RD_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_wb_stage_writeback.sv
// Directed bench for wb_stage_writeback: vector table for write-back formatting,
// hand-written sequences for stall/flush, async reset and counter wrap.
module tb_wb_stage_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, valid_in, reg_write_in;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel_in, byte_off_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, pc_plus4_in, mem_rdata_in;
    logic [31:0] Rin, S, fwd_data, retire_count;
    logic        we, fwd_valid;
    logic [4:0]  fwd_rd;

    int nchecks = 0;
    int nerrors = 0;

    // Reference state: occupancy of the stage and expected retire count.
    logic        m_valid;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    wb_stage_writeback dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
        .wb_sel_in(wb_sel_in), .funct3_in(funct3_in), .byte_off_in(byte_off_in),
        .alu_result_in(alu_result_in), .pc_plus4_in(pc_plus4_in),
        .mem_rdata_in(mem_rdata_in), .Rin(Rin), .we(we), .S(S),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_count(retire_count)
    );

    typedef struct {
        logic        valid;
        logic        regw;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] mem;
        logic [31:0] exp_rin;
        logic        exp_we;
        logic [31:0] exp_s;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_in      = v.valid;
        reg_write_in  = v.regw;
        rd_in         = v.rd;
        wb_sel_in     = v.wb_sel;
        funct3_in     = v.funct3;
        byte_off_in   = v.off;
        alu_result_in = v.alu;
        pc_plus4_in   = v.pc4;
        mem_rdata_in  = v.mem;
    endtask

    // One clock edge with the model updated alongside; returns at the falling edge.
    task automatic step();
        @(posedge clk);
        if (flush) begin
            if (m_valid) m_count = m_count + 32'd1;
            m_valid = 1'b0;
        end else if (!stall) begin
            if (m_valid) m_count = m_count + 32'd1;
            m_valid = valid_in;
        end
        @(negedge clk);
    endtask

    task automatic check_outputs(input string name, input logic [31:0] erin,
                                 input logic ewe, input logic [31:0] es);
        check({name, ".Rin"}, Rin, erin);
        check({name, ".we"}, {31'd0, we}, {31'd0, ewe});
        check({name, ".S"}, S, es);
        check({name, ".fwd"}, {fwd_data ^ Rin, 31'd0, fwd_valid ^ we}, 64'd0 >> 32);
    endtask

    initial begin
        vec_t bubble;
        bubble = '{1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  2'b00, 3'b000, 2'd0, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 1'b1, 32'h00000020};
        vecs[1]  = '{1'b1, 1'b1, 5'd0,  2'b00, 3'b000, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b000, 2'd3, 32'h0, 32'h0, 32'h80FF7F01, 32'hFFFFFF80, 1'b1, 32'h00000008};
        vecs[3]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b100, 2'd3, 32'h0, 32'h0, 32'h80FF7F01, 32'h00000080, 1'b1, 32'h00000008};
        vecs[4]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b000, 2'd1, 32'h0, 32'h0, 32'h80FF7F01, 32'h0000007F, 1'b1, 32'h00000008};
        vecs[5]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b001, 2'd2, 32'h0, 32'h0, 32'h80FF7F01, 32'hFFFF80FF, 1'b1, 32'h00000008};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b101, 2'd0, 32'h0, 32'h0, 32'h80FF7F01, 32'h00007F01, 1'b1, 32'h00000008};
        vecs[7]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b010, 2'd2, 32'h0, 32'h0, 32'h80FF7F01, 32'h80FF7F01, 1'b1, 32'h00000008};
        vecs[8]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b000, 2'd2, 32'h0, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1, 32'h00000008};
        vecs[9]  = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b001, 2'd3, 32'h0, 32'h0, 32'h80FF7F01, 32'hFFFF80FF, 1'b1, 32'h00000008};
        vecs[10] = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b101, 2'd1, 32'h0, 32'h0, 32'h80FF7F01, 32'h00007F01, 1'b1, 32'h00000008};
        vecs[11] = '{1'b1, 1'b1, 5'd3,  2'b01, 3'b111, 2'd1, 32'h0, 32'h0, 32'h80FF7F01, 32'h80FF7F01, 1'b1, 32'h00000008};
        vecs[12] = '{1'b1, 1'b1, 5'd1,  2'b10, 3'b000, 2'd0, 32'h55555555, 32'h00000104, 32'h0, 32'h00000104, 1'b1, 32'h00000002};
        vecs[13] = '{1'b1, 1'b1, 5'd31, 2'b11, 3'b000, 2'd0, 32'hCAFEF00D, 32'h00000104, 32'h0, 32'hCAFEF00D, 1'b1, 32'h80000000};
        vecs[14] = '{1'b1, 1'b0, 5'd9,  2'b00, 3'b000, 2'd0, 32'h00000009, 32'h0, 32'h0, 32'h00000009, 1'b0, 32'h00000000};
        vecs[15] = '{1'b0, 1'b1, 5'd9,  2'b00, 3'b000, 2'd0, 32'h0000000A, 32'h0, 32'h0, 32'h0000000A, 1'b0, 32'h00000000};

        stall = 1'b0;
        flush = 1'b0;
        drive(bubble);
        reset = 1'b0;
        m_valid = 1'b0;
        m_count = 32'd0;
        #12;
        check_outputs("reset", 32'h0, 1'b0, 32'h0);
        check("reset.fwd_rd", {27'd0, fwd_rd}, 32'h0);
        check("reset.retire", retire_count, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_rin, vecs[i].exp_we, vecs[i].exp_s);
            check($sformatf("vec%0d.fwd_rd", i), {27'd0, fwd_rd}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d.retire", i), retire_count, m_count);
        end
        drive(bubble);
        step();
        check("drain.retire", retire_count, 32'd15);

        // Capture rd=7, then hold for three edges while the inputs change underneath.
        drive('{1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 2'd0, 32'h000000AA, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
        step();
        check_outputs("cap7", 32'h000000AA, 1'b1, 32'h00000080);
        stall = 1'b1;
        drive('{1'b1, 1'b1, 5'd9, 2'b10, 3'b000, 2'd0, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 1'b0, 32'h0});
        for (int k = 0; k < 3; k++) begin
            step();
            check_outputs($sformatf("stall%0d", k), 32'h000000AA, 1'b1, 32'h00000080);
            check($sformatf("stall%0d.retire", k), retire_count, 32'd15);
        end
        flush = 1'b1;
        step();
        check_outputs("flush_stall", 32'h0, 1'b0, 32'h0);
        check("flush_stall.retire", retire_count, 32'd16);
        flush = 1'b0;
        stall = 1'b0;

        // JAL link, then asynchronous reset between edges.
        drive('{1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h00000104, 32'h0, 32'h0, 1'b0, 32'h0});
        step();
        check_outputs("jal", 32'h00000104, 1'b1, 32'h00000002);
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.we", {31'd0, we}, 32'd0);
        check("async_rst.S", S, 32'h0);
        check("async_rst.retire", retire_count, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold.we", {31'd0, we}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        m_valid = 1'b0;
        m_count = 32'd0;

        // Counter wrap: preload the counter while the stage holds a bubble.
        drive(bubble);
        step();
        force dut.retire_count_reg = 32'hFFFFFFFF;
        #1;
        release dut.retire_count_reg;
        m_count = 32'hFFFFFFFF;
        drive(vecs[0]);
        step();
        check("wrap.pre", retire_count, 32'hFFFFFFFF);
        drive(bubble);
        step();
        check("wrap.post", retire_count, 32'h00000000);
        check("wrap.model", retire_count, m_count);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1);
    end

endmodule
